avg_window_stats: RTL and testbench

Downstream consumer of the AVG stage. Takes AVG's `done`/`data_out` result stream (signed 8-bit) and groups every WIN consecutive results into a window. For each window it computes minimum, maximum, range (max − min) and sum, then presents them on a valid/ready output port. AVG cannot be stalled, so this block buffers one completed summary and reports windows lost to back-pressure.

---
 rtl/avg_window_stats.sv | 146 ++++++++++++++
 tb/tb_avg_window_stats.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/avg_window_stats.sv
// avg_window_stats
//   Groups every WIN consecutive results of the AVG stage into a window and
//   reports min, max, range (max - min) and sum of each window on a
//   valid/ready port. One completed summary is buffered; a completion that
//   arrives while that buffer is held (out_ready low) is dropped and flagged
//   by the sticky overflow bit.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   sample strobe (AVG done)
//   in_data    signed sample (AVG data_out)
//   clear      synchronous flush of partial window, pending summary, overflow
//   out_valid  summary available
//   out_ready  downstream accepts summary when high with out_valid
//   out_min    signed window minimum
//   out_max    signed window maximum
//   out_range  unsigned out_max - out_min (DW+1 bits)
//   out_sum    signed window sum (DW+log2(WIN) bits, cannot overflow)
//   overflow   sticky: a completed window was dropped
module avg_window_stats #(
  parameter int WIN = 4,
  parameter int DW  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic signed [DW-1:0]              in_data,
  input  logic                              clear,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [DW-1:0]              out_min,
  output logic signed [DW-1:0]              out_max,
  output logic        [DW:0]                out_range,
  output logic signed [DW+$clog2(WIN)-1:0]  out_sum,
  output logic                              overflow
);

  localparam int CW = $clog2(WIN);
  localparam int SW = DW + CW;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic        [CW-1:0] cnt;
  logic signed [DW-1:0] run_min;
  logic signed [DW-1:0] run_max;
  logic signed [SW-1:0] run_sum;
  logic        [0:0]    state;

  logic                 first;
  logic                 last;
  logic                 take;
  logic                 complete;
  logic signed [DW-1:0] nxt_min;
  logic signed [DW-1:0] nxt_max;
  logic signed [SW-1:0] nxt_sum;
  logic        [DW:0]   nxt_range;

  function automatic logic signed [SW-1:0] sext_sum(input logic signed [DW-1:0] v);
    return {{CW{v[DW-1]}}, v};
  endfunction

  // Both operands widened by one sign bit, so the difference of any two
  // DW-bit values fits and max >= min keeps it non-negative.
  function automatic logic [DW:0] range_of(input logic signed [DW-1:0] mx,
                                           input logic signed [DW-1:0] mn);
    logic signed [DW:0] d;
    d = {mx[DW-1], mx} - {mn[DW-1], mn};
    return d;
  endfunction

  // Running values including the current sample; on the first sample of a
  // window the sample alone seeds them.
  always_comb begin
    first     = (cnt == '0);
    last      = (cnt == CW'(WIN - 1));
    take      = in_valid && !clear;
    complete  = take && last;
    nxt_min   = in_data;
    nxt_max   = in_data;
    nxt_sum   = sext_sum(in_data);
    if (!first) begin
      nxt_min = (in_data < run_min) ? in_data : run_min;
      nxt_max = (in_data > run_max) ? in_data : run_max;
      nxt_sum = run_sum + sext_sum(in_data);
    end
    nxt_range = range_of(nxt_max, nxt_min);
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      run_min   <= '0;
      run_max   <= '0;
      run_sum   <= '0;
      state     <= EMPTY;
      overflow  <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
      out_range <= '0;
      out_sum   <= '0;
    end else if (clear) begin
      // Running registers need no flush: cnt=0 makes the next sample reseed them.
      cnt      <= '0;
      state    <= EMPTY;
      overflow <= 1'b0;
    end else begin
      if (take) begin
        cnt     <= last ? '0 : cnt + 1'b1;
        run_min <= nxt_min;
        run_max <= nxt_max;
        run_sum <= nxt_sum;
      end
      case (state)
        EMPTY: begin
          if (complete) begin
            out_min   <= nxt_min;
            out_max   <= nxt_max;
            out_range <= nxt_range;
            out_sum   <= nxt_sum;
            state     <= FULL;
          end
        end
        default: begin
          if (out_ready) begin
            // Accept and refill in the same cycle: no bubble.
            if (complete) begin
              out_min   <= nxt_min;
              out_max   <= nxt_max;
              out_range <= nxt_range;
              out_sum   <= nxt_sum;
            end else begin
              state <= EMPTY;
            end
          end else if (complete) begin
            overflow <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_window_stats.sv
module tb_avg_window_stats;

  localparam int WIN = 4;
  localparam int DW  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [7:0]  in_data = '0;
  logic               clear = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [7:0]  out_min;
  logic signed [7:0]  out_max;
  logic        [8:0]  out_range;
  logic signed [9:0]  out_sum;
  logic               overflow;

  int n_pass = 0;
  int n_total = 0;

  avg_window_stats #(.WIN(WIN), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_range(out_range),
    .out_sum(out_sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural reference: collect samples of the current window in a queue,
  // summarise it with plain arithmetic when WIN have arrived.
  int  win_q[$];
  bit  m_valid;
  bit  m_ovf;
  int  m_min, m_max, m_rng, m_sum;

  task automatic model_reset();
    win_q.delete();
    m_valid = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit clr, input bit rdy);
    bit done;
    int mn, mx, sm;
    done = 0;
    mn = 0; mx = 0; sm = 0;
    if (clr) begin
      win_q.delete();
      m_valid = 0;
      m_ovf   = 0;
      return;
    end
    if (v) begin
      win_q.push_back(d);
      if (win_q.size() == WIN) begin
        mn = win_q[0]; mx = win_q[0]; sm = 0;
        foreach (win_q[i]) begin
          if (win_q[i] < mn) mn = win_q[i];
          if (win_q[i] > mx) mx = win_q[i];
          sm += win_q[i];
        end
        win_q.delete();
        done = 1;
      end
    end
    if (m_valid && !rdy) begin
      if (done) m_ovf = 1;
    end else if (done) begin
      m_valid = 1;
      m_min = mn; m_max = mx; m_rng = mx - mn; m_sum = sm;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs, advance the model, and land 2ns after the edge.
  task automatic apply(input bit v, input int d, input bit clr, input bit rdy);
    in_valid  = v;
    in_data   = d[7:0];
    clear     = clr;
    out_ready = rdy;
    model_step(v, d, clr, rdy);
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    bit v; int d; bit clr; bit rdy;
    bit ev; int emin; int emax; int erng; int esum; bit eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(bit v, int d, bit clr, bit rdy, bit ev,
                               int mn, int mx, int rg, int sm, bit eo);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.rdy = rdy;
    r.ev = ev; r.emin = mn; r.emax = mx; r.erng = rg; r.esum = sm; r.eo = eo;
    return r;
  endfunction

  initial begin
    // basic window
    tbl.push_back(row(1,  10, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,  -5, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,   3, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,   7, 0, 1, 1, -5, 10, 15, 15, 0));
    tbl.push_back(row(0,   0, 0, 1, 0, 0, 0, 0, 0, 0));
    // extremes with gaps
    tbl.push_back(row(1, -128, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,  127, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0,    0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0,    0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,    0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,   -1, 0, 1, 1, -128, 127, 255, -2, 0));
    tbl.push_back(row(0,    0, 0, 1, 0, 0, 0, 0, 0, 0));
    // back-pressure and overflow
    tbl.push_back(row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 4, 0, 0, 1, 1, 4, 3, 10, 0));
    tbl.push_back(row(1, 5, 0, 0, 1, 1, 4, 3, 10, 0));
    tbl.push_back(row(1, 6, 0, 0, 1, 1, 4, 3, 10, 0));
    tbl.push_back(row(1, 7, 0, 0, 1, 1, 4, 3, 10, 0));
    tbl.push_back(row(1, 8, 0, 0, 1, 1, 4, 3, 10, 1));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    // clear priority: pending summary and overflow set, sample 9 with clear
    tbl.push_back(row(1, 20, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 21, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 22, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 23, 0, 0, 1, 20, 23, 3, 86, 1));
    tbl.push_back(row(1,  9, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,  1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,  1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,  1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1,  2, 0, 1, 1, 1, 2, 1, 5, 0));
    // simultaneous accept and completion
    tbl.push_back(row(1, -3, 0, 0, 1, 1, 2, 1, 5, 0));
    tbl.push_back(row(1, -3, 0, 0, 1, 1, 2, 1, 5, 0));
    tbl.push_back(row(1, -3, 0, 0, 1, 1, 2, 1, 5, 0));
    tbl.push_back(row(1, -7, 0, 1, 1, -7, -3, 4, -16, 0));
    tbl.push_back(row(0,  0, 0, 1, 0, 0, 0, 0, 0, 0));

    // reset state
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_min",   out_min, 0);
    chk("rst_max",   out_max, 0);
    chk("rst_range", out_range, 0);
    chk("rst_sum",   out_sum, 0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ovf", i),   overflow,  tbl[i].eo);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_min", i),   out_min,   tbl[i].emin);
        chk($sformatf("tbl%0d_max", i),   out_max,   tbl[i].emax);
        chk($sformatf("tbl%0d_range", i), out_range, tbl[i].erng);
        chk($sformatf("tbl%0d_sum", i),   out_sum,   tbl[i].esum);
      end
    end

    // reset mid-window: output registers still hold the last summary
    apply(1, 50, 0, 1);
    apply(1, 60, 0, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf",   overflow, 0);
    chk("arst_min",   out_min, 0);
    chk("arst_max",   out_max, 0);
    chk("arst_range", out_range, 0);
    chk("arst_sum",   out_sum, 0);
    #1;
    rst = 1'b0;
    apply(1, 1, 0, 1);
    apply(1, 2, 0, 1);
    apply(1, 3, 0, 1);
    chk("arst_nowin", out_valid, 0);
    apply(1, 4, 0, 1);
    chk("arst_valid2", out_valid, 1);
    chk("arst_min2",   out_min, 1);
    chk("arst_max2",   out_max, 4);
    chk("arst_range2", out_range, 3);
    chk("arst_sum2",   out_sum, 10);
    apply(0, 0, 0, 1);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      bit v, clr, rdy;
      int d;
      v   = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      d   = $signed(8'($urandom_range(0, 255)));
      apply(v, d, clr, rdy);
      chk("rnd_valid", out_valid, m_valid);
      chk("rnd_ovf",   overflow,  m_ovf);
      if (m_valid) begin
        chk("rnd_min",   out_min,   m_min);
        chk("rnd_max",   out_max,   m_max);
        chk("rnd_range", out_range, m_rng);
        chk("rnd_sum",   out_sum,   m_sum);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
